// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and helpers for the memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef PROC_COUNT
`define PROC_COUNT 4
`endif

package mem_arb_pkg;

    localparam int c_ADDR_W = 32;

    typedef logic [c_ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Sizes above four words saturate to a full 128-bit line.
    function automatic logic [3:0] size_to_mask(input logic [2:0] size);
        case (size)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick starting just above i_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    int w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int i = 1; i <= N; i++) begin
            w_pos = (int'(i_ptr) + i) % N;
            if (!o_valid && i_req[w_pos[IDX_W-1:0]]) begin
                o_valid                     = 1'b1;
                o_idx                       = w_pos[IDX_W-1:0];
                o_grant[w_pos[IDX_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb
// Brief    : Round-robin arbiter giving PROC_COUNT processors one-at-a-time
//            access to a single synchronous 128-bit memory port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int PROC_COUNT = `PROC_COUNT
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [PROC_COUNT-1:0] i_req_rd,
    input  logic [PROC_COUNT-1:0] i_req_wr,
    input  addr_t                 i_addr    [PROC_COUNT],
    input  logic [127:0]          i_data    [PROC_COUNT],
    input  logic [2:0]            i_wr_size [PROC_COUNT],
    output logic [PROC_COUNT-1:0] o_grant_rd,
    output logic [PROC_COUNT-1:0] o_grant_wr,
    output logic [PROC_COUNT-1:0] o_valid,
    output logic [127:0]          o_data,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output addr_t                 o_mem_addr,
    output logic [127:0]          o_mem_wdata,
    output logic [3:0]            o_mem_wmask,
    input  logic [127:0]          i_mem_rdata
);

    localparam int c_IDX_W = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic [c_IDX_W-1:0]      r_last_winner;
    logic [c_IDX_W-1:0]      w_rr_idx;
    logic [PROC_COUNT-1:0]   w_req_any;
    logic [PROC_COUNT-1:0]   w_rr_grant;
    logic [PROC_COUNT-1:0]   r_win_oh;
    logic                    w_rr_valid;
    logic                    w_arb;
    logic                    r_op_wr;
    addr_t                   r_addr;
    logic [127:0]            r_wdata;
    logic [127:0]            r_rdata_hold;
    logic [3:0]              r_wmask;

    assign w_req_any = i_req_rd | i_req_wr;

    rr_arbiter #(
        .N     (PROC_COUNT),
        .IDX_W (c_IDX_W)
    ) u_rr_arbiter (
        .i_req   (w_req_any),
        .i_ptr   (r_last_winner),
        .o_grant (w_rr_grant),
        .o_idx   (w_rr_idx),
        .o_valid (w_rr_valid)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Outputs decode from state so an asynchronous reset clears them at once.
    always_comb begin
        w_state_nxt = r_state;
        w_arb       = 1'b0;
        o_grant_rd  = '0;
        o_grant_wr  = '0;
        o_valid     = '0;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_wmask = '0;
        o_data      = r_rdata_hold;
        case (r_state)
            IDLE: begin
                if (w_rr_valid) begin
                    w_arb       = 1'b1;
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                o_mem_en    = 1'b1;
                o_mem_we    = r_op_wr;
                o_mem_addr  = r_addr;
                o_mem_wdata = r_wdata;
                o_mem_wmask = r_wmask;
                if (r_op_wr) begin
                    o_grant_wr  = r_win_oh;
                    w_state_nxt = IDLE;
                end else begin
                    o_grant_rd  = r_win_oh;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                o_valid     = r_win_oh;
                o_data      = i_mem_rdata;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A proc with both requests up is served as a read; its write waits.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_last_winner <= c_IDX_W'(PROC_COUNT - 1);
            r_win_oh      <= '0;
            r_op_wr       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wmask       <= '0;
            r_rdata_hold  <= '0;
        end else begin
            if (w_arb) begin
                r_last_winner <= w_rr_idx;
                r_win_oh      <= w_rr_grant;
                r_op_wr       <= !i_req_rd[w_rr_idx];
                r_addr        <= i_addr[w_rr_idx];
                r_wdata       <= i_data[w_rr_idx];
                r_wmask       <= i_req_rd[w_rr_idx] ? 4'b0000
                                                    : size_to_mask(i_wr_size[w_rr_idx]);
            end
            if (r_state == RESP) begin
                r_rdata_hold <= i_mem_rdata;
            end
        end
    end

endmodule

`default_nettype wire
